bpt_controller: RTL and testbench

Branch prediction table controller that owns a single-ported table of 2-bit saturating counters, one per branch index.
It arbitrates each cycle between prediction lookups and resolved-branch updates, and queues updates in a small FIFO so lookups are never stalled in normal operation.
A starvation guard forces update drain when lookups monopolise the table.
It sits between fetch (lookup side) and execute (resolve side).

---
 rtl/bpt_pkg.sv | 36 +++
 rtl/bpt_update_fifo.sv | 77 +++++++
 rtl/bpt_controller.sv | 146 ++++++++++++++
 tb/tb_bpt_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bpt_pkg.sv
// Shared definitions for the branch prediction table controller.
//   - bpt_cnt_e    : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - bpt_upd_t    : queued update record {idx, taken}
//   - bpt_sat_next : counter step for one resolved branch outcome
// The idx field is sized to the largest supported index width; the
// controller zero-extends on push and truncates on pop.
package bpt_pkg;

    localparam int unsigned BPT_IDX_MAX_W = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bpt_cnt_e;

    typedef struct packed {
        logic [BPT_IDX_MAX_W-1:0] idx;
        logic                     taken;
    } bpt_upd_t;

    function automatic bpt_cnt_e bpt_sat_next(input bpt_cnt_e cur, input logic taken);
        bpt_cnt_e nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = SNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bpt_update_fifo.sv
// Update FIFO holding resolved branches until the table port is free.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_data       : enqueue request (ignored when full)
//   pop, pop_data         : dequeue request (ignored when empty), head entry
//   full, empty, count    : status derived from the registered occupancy
// QDEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module bpt_update_fifo
    import bpt_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  bpt_upd_t         push_data,
    input  logic             pop,
    output bpt_upd_t         pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);

    bpt_upd_t         mem_q [QDEPTH];
    bpt_upd_t         mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == CNT_W'(QDEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/bpt_controller.sv
// Branch prediction table controller.
// Owns a single-ported table of 2-bit saturating counters and arbitrates the
// port each cycle between a fetch lookup and a queued resolve-side update.
// Priority: forced commit (starvation guard) > lookup > normal commit.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   pred_req, pred_idx, pred_ready  : lookup handshake
//   pred_valid, prediction          : lookup result, one cycle after accept
//   upd_req, upd_idx, upd_taken     : resolved-branch update handshake
//   upd_ready, q_count              : update FIFO space / occupancy
//   mispredict_cnt                  : only with BPT_MISPREDICT_STATS_EN
// Optional feature macro: BPT_MISPREDICT_STATS_EN
module bpt_controller
    import bpt_pkg::*;
#(
    parameter int unsigned INDEX_W    = 4,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_req,
    input  logic [INDEX_W-1:0]         pred_idx,
    output logic                       pred_ready,
    output logic                       pred_valid,
    output logic                       prediction,
    input  logic                       upd_req,
    input  logic [INDEX_W-1:0]         upd_idx,
    input  logic                       upd_taken,
    output logic                       upd_ready,
`ifdef BPT_MISPREDICT_STATS_EN
    output logic [15:0]                mispredict_cnt,
`endif
    output logic [$clog2(QDEPTH+1)-1:0] q_count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_W;
    localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);
    localparam int unsigned ST_W    = $clog2(STARVE_MAX + 1);

    bpt_cnt_e           table_q [ENTRIES];
    bpt_cnt_e           table_d [ENTRIES];
    logic [ST_W-1:0]    starve_q, starve_d;
    logic               pred_valid_q, pred_valid_d;
    logic               prediction_q, prediction_d;

    logic               fifo_full;
    logic               fifo_empty;
    bpt_upd_t           push_data;
    bpt_upd_t           head;
    logic [INDEX_W-1:0] head_idx;
    bpt_cnt_e           head_entry;
    logic               force_commit;
    logic               accept;
    logic               commit;

    always_comb begin
        push_data = '{idx: BPT_IDX_MAX_W'(upd_idx), taken: upd_taken};
    end

    bpt_update_fifo #(
        .QDEPTH (QDEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_req),
        .push_data (push_data),
        .pop       (commit),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count)
    );

    // Arbitration. Emptiness comes from the registered count, so an update
    // pushed this cycle cannot be committed until the next one.
    always_comb begin
        force_commit = (starve_q == ST_W'(STARVE_MAX)) && !fifo_empty;
        accept       = pred_req && !force_commit;
        commit       = force_commit || (!pred_req && !fifo_empty);
        head_idx     = INDEX_W'(head.idx);
        head_entry   = table_q[head_idx];
    end

    always_comb begin
        table_d = table_q;
        if (commit) begin
            table_d[head_idx] = bpt_sat_next(head_entry, head.taken);
        end

        // Counts cycles where a queued update was denied the port.
        starve_d = starve_q;
        if (fifo_empty || commit) begin
            starve_d = '0;
        end else if (starve_q != ST_W'(STARVE_MAX)) begin
            starve_d = starve_q + ST_W'(1);
        end

        pred_valid_d = accept;
        prediction_d = accept && table_q[pred_idx][1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= SNT;
            end
            starve_q     <= '0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
        end else begin
            table_q      <= table_d;
            starve_q     <= starve_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
        end
    end

    assign pred_ready = !force_commit;
    assign upd_ready  = !fifo_full;
    assign pred_valid = pred_valid_q;
    assign prediction = prediction_q;

`ifdef BPT_MISPREDICT_STATS_EN
    logic [15:0] mispredict_q, mispredict_d;

    always_comb begin
        mispredict_d = mispredict_q;
        if (commit && (head_entry[1] != head.taken) && (mispredict_q != '1)) begin
            mispredict_d = mispredict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_q <= '0;
        end else begin
            mispredict_q <= mispredict_d;
        end
    end

    assign mispredict_cnt = mispredict_q;
`endif

endmodule

// File: tb/tb_bpt_controller.sv
// Testbench for bpt_controller: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_bpt_controller;

    localparam int INDEX_W    = 4;
    localparam int QDEPTH     = 4;
    localparam int STARVE_MAX = 3;
    localparam int ENTRIES    = 2 ** INDEX_W;
    localparam int CNT_W      = $clog2(QDEPTH + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               pred_req = 1'b0;
    logic [INDEX_W-1:0] pred_idx = '0;
    logic               pred_ready;
    logic               pred_valid;
    logic               prediction;
    logic               upd_req = 1'b0;
    logic [INDEX_W-1:0] upd_idx = '0;
    logic               upd_taken = 1'b0;
    logic               upd_ready;
    logic [CNT_W-1:0]   q_count;
`ifdef BPT_MISPREDICT_STATS_EN
    logic [15:0]        mispredict_cnt;
`endif

    bpt_controller #(
        .INDEX_W    (INDEX_W),
        .QDEPTH     (QDEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_req   (pred_req),
        .pred_idx   (pred_idx),
        .pred_ready (pred_ready),
        .pred_valid (pred_valid),
        .prediction (prediction),
        .upd_req    (upd_req),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
`ifdef BPT_MISPREDICT_STATS_EN
        .mispredict_cnt (mispredict_cnt),
`endif
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers 0..3, FIFO as a queue.
    typedef struct {
        int idx;
        bit taken;
    } upd_rec_t;

    int       m_tbl [ENTRIES];
    upd_rec_t m_q [$];
    int       m_starve;
    int       m_mis;
    int       n_checks = 0;
    int       n_fail   = 0;
    int       n_force  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 0;
        m_q.delete();
        m_starve = 0;
        m_mis    = 0;
    endtask

    // One clock cycle: drive at negedge, check pre-edge status, advance the
    // model, then check the registered lookup result after the edge.
    task automatic step(input bit pr, input int pi, input bit ur, input int ui, input bit ut);
        bit       frc, acc, cmt;
        bit       exp_pred;
        int       qlen;
        upd_rec_t h;
        @(negedge clk);
        pred_req  = pr;
        pred_idx  = INDEX_W'(pi);
        upd_req   = ur;
        upd_idx   = INDEX_W'(ui);
        upd_taken = ut;
        #1;
        qlen = m_q.size();
        frc  = (m_starve >= STARVE_MAX) && (qlen > 0);
        acc  = pr && !frc;
        cmt  = frc || (!pr && qlen > 0);
        if (frc) n_force++;
        check("pred_ready", pred_ready, !frc);
        check("upd_ready", upd_ready, qlen != QDEPTH);
        check("q_count", q_count, qlen);
        exp_pred = acc ? (m_tbl[pi] >= 2) : 1'b0;
        if (cmt) begin
            h = m_q.pop_front();
            if ((m_tbl[h.idx] >= 2) != h.taken && m_mis < 65535) m_mis++;
            if (h.taken) m_tbl[h.idx] = (m_tbl[h.idx] == 3) ? 3 : m_tbl[h.idx] + 1;
            else         m_tbl[h.idx] = (m_tbl[h.idx] == 0) ? 0 : m_tbl[h.idx] - 1;
        end
        if (ur && qlen < QDEPTH) m_q.push_back('{idx: ui, taken: ut});
        if (qlen == 0 || cmt) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        @(posedge clk);
        #1;
        check("pred_valid", pred_valid, acc);
        if (acc) check("prediction", prediction, exp_pred);
`ifdef BPT_MISPREDICT_STATS_EN
        check("mispredict_cnt", mispredict_cnt, m_mis);
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 20) begin
            idle();
            guard++;
        end
        check("drain_bound", q_count, 0);
    endtask

    task automatic reset_checks();
        #1;
        check("rst_q_count", q_count, 0);
        check("rst_upd_ready", upd_ready, 1);
        check("rst_pred_ready", pred_ready, 1);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_prediction", prediction, 0);
`ifdef BPT_MISPREDICT_STATS_EN
        check("rst_mispredict", mispredict_cnt, 0);
`endif
        model_clear();
    endtask

    initial begin
        int f0;
        model_clear();
        #12;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;

        // Cold lookup returns not-taken.
        step(1, 5, 0, 0, 0);
        check("cold_pred5", prediction, 0);

        // Three taken updates saturate to ST, a fourth keeps it there.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1);
        drain();
        step(1, 5, 0, 0, 0);
        check("pred5_taken", prediction, 1);
        step(0, 0, 1, 5, 1);
        drain();
        step(1, 5, 0, 0, 0);
        check("pred5_sat", prediction, 1);

        // Fill the FIFO while lookups hog the port; the guard must force.
        f0 = n_force;
        for (int i = 0; i < 4; i++) step(1, i, 1, 7, i[0]);
        check("full_upd_ready", upd_ready, 0);
        step(1, 3, 0, 0, 0);
        check("forced_once", n_force - f0, 1);
        check("q_after_force", q_count, 3);
        drain();

        // Lookup sees the stale value while an update to the same index is queued.
        step(0, 0, 1, 2, 1);
        step(0, 0, 1, 2, 1);
        drain();
        step(1, 2, 1, 2, 0);
        check("stale_pred2", prediction, 1);
        drain();
        step(1, 2, 0, 0, 0);
        check("pred2_after", prediction, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, ENTRIES - 1),
                 $urandom_range(0, 99) < 55, $urandom_range(0, 3), $urandom_range(0, 1));
        end
        check("random_forced", n_force > f0 + 1, 1);

        // Reset while three updates are still queued.
        drain();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 9, 1);
        check("pre_rst_q", q_count, 3);
        @(negedge clk);
        pred_req = 1'b0;
        upd_req  = 1'b0;
        #2 reset = 1'b1;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < ENTRIES; i++) step(1, i, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
